// File: rtl/zcache_nway.sv
// N-way (1 or 2) set-associative read cache with write-update, LRU replacement,
// uncached bypass reads and a one-set-per-cycle invalidation sweep.
module zcache_nway #(
  parameter int WAYS   = 2,
  parameter int IDX_W  = 8,
  parameter int PAGE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [PAGE_W+12:0]  addr,
  input  logic                wbsel,
  input  logic [7:0]          wdata,
  input  logic                en,
  input  logic                flush,
  output logic                rd_valid,
  output logic [15:0]         rd_data,
  output logic                hit,
  output logic                busy,
  output logic                dram_req,
  output logic [PAGE_W+12:0]  dram_addr,
  input  logic                dram_next,
  input  logic                dram_strobe,
  input  logic [15:0]         dram_rddata
);

  localparam int AW    = PAGE_W + 13;
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = AW - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, FLUSH} state_t;

  function automatic logic [15:0] merge_byte(input logic [15:0] d, input logic sel,
                                             input logic [7:0] b);
    return sel ? {b, d[7:0]} : {d[15:8], b};
  endfunction

  logic [WAYS-1:0]  valid_mem [SETS];
  logic             lru_mem   [SETS];
  logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
  logic [15:0]      data_mem  [WAYS][SETS];

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             flush_pend, rd_pend, alloc_p1, dram_req_r;
  logic [IDX_W-1:0] idx_p1;

  logic [IDX_W-1:0] set_idx;
  logic [TAG_W-1:0] tag_in;
  logic             lk_hit, wr_hit, fill_fire, fill_alloc;
  logic [0:0]       hit_way, wr_way, victim;
  logic [15:0]      lk_data, fill_data;

  assign set_idx   = addr[IDX_W-1:0];
  assign tag_in    = addr[AW-1:IDX_W];
  assign dram_addr = addr;
  assign dram_req  = dram_req_r;
  assign busy      = (state != IDLE);

  always_comb begin
    lk_hit  = 1'b0;
    hit_way = '0;
    wr_hit  = 1'b0;
    wr_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[idx_p1][w] && tag_mem[w][idx_p1] == tag_in) begin
        lk_hit  = 1'b1;
        hit_way = 1'(w);
      end
      if (valid_mem[set_idx][w] && tag_mem[w][set_idx] == tag_in) begin
        wr_hit = 1'b1;
        wr_way = 1'(w);
      end
    end
    lk_data = data_mem[hit_way][idx_p1];
  end

  // Victim: first invalid way (way 0 first), otherwise the set's LRU way.
  always_comb begin
    victim = '0;
    if (WAYS > 1) begin
      if (!valid_mem[set_idx][0])           victim = 1'b0;
      else if (!valid_mem[set_idx][WAYS-1]) victim = 1'b1;
      else                                  victim = lru_mem[set_idx];
    end
  end

  assign fill_fire  = (state == FILL) && dram_strobe && !rst;
  assign fill_alloc = fill_fire && alloc_p1;
  assign fill_data  = req_wr ? merge_byte(dram_rddata, wbsel, wdata) : dram_rddata;

  assign rd_valid = !rst && (((state == LOOKUP) && lk_hit) || fill_fire);
  assign hit      = !rst && (state == LOOKUP) && lk_hit;
  assign rd_data  = (state == FILL) ? dram_rddata : lk_data;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (flush || flush_pend) state_nxt = FLUSH;
        else if (rd_pend)        state_nxt = FILL;
        else if (req_rd)         state_nxt = en ? LOOKUP : FILL;
      end
      LOOKUP: state_nxt = lk_hit ? IDLE : FILL;
      FILL:   if (dram_strobe) state_nxt = IDLE;
      FLUSH:  if (&cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FLUSH;
      cnt        <= '0;
      flush_pend <= 1'b0;
      rd_pend    <= 1'b0;
      alloc_p1   <= 1'b0;
      dram_req_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == FLUSH) ? cnt + 1'b1 : '0;
      if (state == IDLE) flush_pend <= 1'b0;
      else if (flush)    flush_pend <= 1'b1;
      // A read that collides with a flush waits out the sweep, then goes uncached.
      if (state == IDLE)
        rd_pend <= (flush || flush_pend) ? (rd_pend || req_rd) : 1'b0;
      else if (state == FLUSH && req_rd)
        rd_pend <= 1'b1;
      if (state == IDLE) alloc_p1 <= en && !rd_pend;
      if (state != FILL && state_nxt == FILL)
        dram_req_r <= 1'b1;
      else if (state == FILL && (dram_next || dram_strobe))
        dram_req_r <= 1'b0;
    end
  end

  // ---- p1: registered set index feeding the lookup read; array updates ----
  always_ff @(posedge clk) begin
    if (state == IDLE) idx_p1 <= set_idx;
    if (state == FLUSH) begin
      valid_mem[cnt] <= '0;
      lru_mem[cnt]   <= 1'b0;
    end
    if (state == LOOKUP && lk_hit && !rst) lru_mem[idx_p1] <= ~hit_way;
    if (req_wr && wr_hit && !rst)
      data_mem[wr_way][set_idx] <= merge_byte(data_mem[wr_way][set_idx], wbsel, wdata);
    if (fill_alloc) begin
      valid_mem[set_idx][victim] <= 1'b1;
      tag_mem[victim][set_idx]   <= tag_in;
      data_mem[victim][set_idx]  <= fill_data;
      lru_mem[set_idx]           <= ~victim;
    end
  end

endmodule
